// File: rtl/vga_timing_gen_if.sv
// Raster timing bus: the generator consumes CE/EN and drives sync, enable, counters and strobes.
// Slave is the generator side; master is the consumer that paces it and reads the timing.
interface vga_timing_gen_if #(
  parameter int CW = 12
);
  logic          CE;
  logic          EN;
  logic          HS;
  logic          VS;
  logic          DE;
  logic [CW-1:0] HCNT;
  logic [CW-1:0] VCNT;
  logic          LINE_START;
  logic          FRAME_START;

  modport master (
    output CE, EN,
    input  HS, VS, DE, HCNT, VCNT, LINE_START, FRAME_START
  );

  modport slave (
    input  CE, EN,
    output HS, VS, DE, HCNT, VCNT, LINE_START, FRAME_START
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: H/V counters, sync pulses, display enable and frame/line strobes.
// All outputs registered, one CLK after a CE edge; CE=0 freezes every output (no other backpressure).
module vga_timing_gen #(
  parameter int HACTIVE = 640,
  parameter int HFRONT  = 16,
  parameter int HWIDTH  = 96,
  parameter int HBACK   = 48,
  parameter int VACTIVE = 480,
  parameter int VFRONT  = 10,
  parameter int VWIDTH  = 2,
  parameter int VBACK   = 33,
  parameter int HS_POL  = 0,
  parameter int VS_POL  = 0,
  parameter int CW      = 12
) (
  input  logic               CLK,
  input  logic               RST,
  vga_timing_gen_if.slave    bus
);

  localparam int HTOTAL = HACTIVE + HFRONT + HWIDTH + HBACK;
  localparam int VTOTAL = VACTIVE + VFRONT + VWIDTH + VBACK;

  localparam logic [CW-1:0] H_LAST     = CW'(HTOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(VTOTAL - 1);
  localparam logic [CW-1:0] H_ACT_LAST = CW'(HACTIVE - 1);
  localparam logic [CW-1:0] V_ACT_LAST = CW'(VACTIVE - 1);
  localparam logic [CW-1:0] HS_FIRST   = CW'(HACTIVE + HFRONT);
  localparam logic [CW-1:0] HS_LAST    = CW'(HACTIVE + HFRONT + HWIDTH - 1);
  localparam logic [CW-1:0] VS_FIRST   = CW'(VACTIVE + VFRONT);
  localparam logic [CW-1:0] VS_LAST    = CW'(VACTIVE + VFRONT + VWIDTH - 1);
  localparam logic          HS_ACT     = 1'(HS_POL);
  localparam logic          VS_ACT     = 1'(VS_POL);

  if ((HTOTAL > (1 << CW)) || (VTOTAL > (1 << CW))) begin : g_cw_check
    $error("vga_timing_gen: HTOTAL/VTOTAL do not fit in CW bits");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] vcnt_q, vcnt_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          de_q, de_d;
  logic          ls_q, ls_d;
  logic          fs_q, fs_d;
  logic          run_d;

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    if (bus.CE) begin
      unique case (state_q)
        IDLE: begin
          if (bus.EN) begin
            state_d = RUN;
            hcnt_d  = '0;
            vcnt_d  = '0;
          end
        end
        RUN: begin
          if (!bus.EN) begin
            state_d = IDLE;
            hcnt_d  = '0;
            vcnt_d  = '0;
          end else if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + CW'(1);
          end else begin
            hcnt_d = hcnt_q + CW'(1);
          end
        end
      endcase
    end

    // Decode from the next counts so every output registers in step with HCNT/VCNT.
    run_d = (state_d == RUN);
    hs_d  = (run_d && hcnt_d >= HS_FIRST && hcnt_d <= HS_LAST) ? HS_ACT : ~HS_ACT;
    vs_d  = (run_d && vcnt_d >= VS_FIRST && vcnt_d <= VS_LAST) ? VS_ACT : ~VS_ACT;
    de_d  = run_d && (hcnt_d <= H_ACT_LAST) && (vcnt_d <= V_ACT_LAST);
    ls_d  = run_d && (hcnt_d == '0);
    fs_d  = ls_d && (vcnt_d == '0);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      hs_q    <= ~HS_ACT;
      vs_q    <= ~VS_ACT;
      de_q    <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  assign bus.HS          = hs_q;
  assign bus.VS          = vs_q;
  assign bus.DE          = de_q;
  assign bus.HCNT        = hcnt_q;
  assign bus.VCNT        = vcnt_q;
  assign bus.LINE_START  = ls_q;
  assign bus.FRAME_START = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a 14x8 raster, both sync polarities side by side.
module tb_vga_timing_gen;

  localparam int CW = 12;

  typedef logic [2*CW+4:0] vec_t;
  typedef struct packed {
    vec_t n;
    vec_t p;
  } exp_t;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  vga_timing_gen_if #(.CW(CW)) bn ();
  vga_timing_gen_if #(.CW(CW)) bp ();

  vga_timing_gen #(
    .HACTIVE(8), .HFRONT(2), .HWIDTH(3), .HBACK(1),
    .VACTIVE(4), .VFRONT(1), .VWIDTH(2), .VBACK(1),
    .HS_POL(0), .VS_POL(0), .CW(CW)
  ) dut_n (
    .CLK(CLK),
    .RST(RST),
    .bus(bn)
  );

  vga_timing_gen #(
    .HACTIVE(8), .HFRONT(2), .HWIDTH(3), .HBACK(1),
    .VACTIVE(4), .VFRONT(1), .VWIDTH(2), .VBACK(1),
    .HS_POL(1), .VS_POL(1), .CW(CW)
  ) dut_p (
    .CLK(CLK),
    .RST(RST),
    .bus(bp)
  );

  exp_t sb[$];
  bit   m_run;
  int   m_h, m_v;
  int   pass_cnt = 0;
  int   tot_cnt  = 0;
  int   fs_seen, ls_seen, de_hi, hs_lo, vs_lo;

  function automatic vec_t model_vec(bit run, int h, int v, bit hp, bit vp);
    logic hs, vs, de, ls, fs;
    vec_t r;
    if (!run) begin
      r = {~hp, ~vp, 3'b000, CW'(0), CW'(0)};
      return r;
    end
    hs = (h >= 10 && h <= 12) ? hp : ~hp;
    vs = (v >= 5 && v <= 6) ? vp : ~vp;
    de = (h < 8) && (v < 4);
    ls = (h == 0);
    fs = (h == 0) && (v == 0);
    r  = {hs, vs, de, ls, fs, CW'(h), CW'(v)};
    return r;
  endfunction

  function automatic vec_t vec_n();
    return {bn.HS, bn.VS, bn.DE, bn.LINE_START, bn.FRAME_START, bn.HCNT, bn.VCNT};
  endfunction

  function automatic vec_t vec_p();
    return {bp.HS, bp.VS, bp.DE, bp.LINE_START, bp.FRAME_START, bp.HCNT, bp.VCNT};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tot_cnt++;
    assert (got === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  task automatic push_model();
    exp_t e;
    e.n = model_vec(m_run, m_h, m_v, 1'b0, 1'b0);
    e.p = model_vec(m_run, m_h, m_v, 1'b1, 1'b1);
    sb.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      tot_cnt++;
      $error("FAIL %s_empty observed=0 expected=1 queued", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_pol0"}, 32'(vec_n()), 32'(e.n));
      chk({tag, "_pol1"}, 32'(vec_p()), 32'(e.p));
    end
  endtask

  task automatic step(input bit ce, input bit en, input string tag);
    bn.CE = ce; bn.EN = en;
    bp.CE = ce; bp.EN = en;
    if (ce) begin
      if (!m_run) begin
        if (en) begin
          m_run = 1'b1; m_h = 0; m_v = 0;
        end
      end else if (!en) begin
        m_run = 1'b0; m_h = 0; m_v = 0;
      end else if (m_h == 13) begin
        m_h = 0;
        m_v = (m_v == 7) ? 0 : m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
    end
    push_model();
    @(posedge CLK);
    #1;
    check_out(tag);
    fs_seen += int'(bn.FRAME_START);
    ls_seen += int'(bn.LINE_START);
    de_hi   += int'(bn.DE);
    hs_lo   += int'(!bn.HS);
    vs_lo   += int'(!bn.VS);
  endtask

  initial begin
    RST = 1'b1;
    bn.CE = 1'b0; bn.EN = 1'b0;
    bp.CE = 1'b0; bp.EN = 1'b0;
    m_run = 1'b0; m_h = 0; m_v = 0;
    fs_seen = 0; ls_seen = 0; de_hi = 0; hs_lo = 0; vs_lo = 0;

    #12;
    push_model();
    check_out("reset");
    @(negedge CLK);
    RST = 1'b0;

    step(1'b0, 1'b1, "idle_ce0");
    step(1'b1, 1'b0, "idle_en0");

    // One full frame from the (0,0) start, tallying strobes and levels.
    fs_seen = 0; ls_seen = 0; de_hi = 0; hs_lo = 0; vs_lo = 0;
    step(1'b1, 1'b1, "start");
    for (int i = 0; i < 111; i++) step(1'b1, 1'b1, "frame");
    chk("frame_fs_count", 32'(fs_seen), 32'd1);
    chk("frame_ls_count", 32'(ls_seen), 32'd8);
    chk("frame_de_count", 32'(de_hi), 32'd32);
    chk("frame_hs_low",   32'(hs_lo), 32'd24);
    chk("frame_vs_low",   32'(vs_lo), 32'd28);
    step(1'b1, 1'b1, "frame_wrap");

    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, "ce3_adv");
      step(1'b0, 1'b1, "ce3_hold1");
      step(1'b0, 1'b1, "ce3_hold2");
    end

    for (int i = 0; i < 200 && !(m_h == 5 && m_v == 2); i++) step(1'b1, 1'b1, "seek52");
    chk("reach52", 32'({bn.HCNT, bn.VCNT}), 32'({12'd5, 12'd2}));
    step(1'b1, 1'b0, "en_drop");
    step(1'b0, 1'b1, "idle_hold");
    step(1'b1, 1'b1, "en_restart");

    for (int i = 0; i < 200 && !(m_h == 9 && m_v == 3); i++) step(1'b1, 1'b1, "seek93");
    chk("reach93", 32'({bn.HCNT, bn.VCNT}), 32'({12'd9, 12'd3}));
    #1;
    RST = 1'b1;
    #1;
    m_run = 1'b0; m_h = 0; m_v = 0;
    push_model();
    check_out("async_rst");
    @(negedge CLK);
    RST = 1'b0;
    step(1'b1, 1'b1, "rst_restart");
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, "tail");

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
